// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants for the SPI slave port
package spi_pkg;
   // SPI mode served by this endpoint: clock idles low, data sampled on the trailing edge
   localparam int SPI_CPOL = 0;
   localparam int SPI_CPHA = 1;

   localparam int DEFAULT_DATA_WIDTH  = 8;
   localparam int DEFAULT_SYNC_STAGES = 2;

   // Frame state encoding
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;
endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - pin synchronizer with registered rise/fall pulses
module spi_sync_edge
   import spi_pkg::*;
#(
   parameter int   SYNC_STAGES = DEFAULT_SYNC_STAGES,
   parameter logic RESET_VAL   = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;
   logic                   level;

   assign level = sync_q[SYNC_STAGES-1];

   // Synchronize the pin, then compare against one history flop; pulses are
   // registered so an edge shows up SYNC_STAGES+1 clocks after the pin moves.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= {SYNC_STAGES{RESET_VAL}};
         hist_q <= RESET_VAL;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
         hist_q <= level;
         rise   <= level & ~hist_q;
         fall   <= ~level & hist_q;
      end
   end

endmodule

// File: rtl/spi_slave_port.sv
// rtl/spi_slave_port.sv - SPI mode 1 slave with one-word tx buffer
module spi_slave_port
   import spi_pkg::*;
#(
   parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
   parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  busy,
   output logic                  tx_underrun,
   output logic                  frame_error,
   input  logic                  sclk,
   input  logic                  cs,
   input  logic                  mosi,
   output logic                  miso,
   output logic                  miso_oe
);

   localparam int               CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   logic [0:0]             state_q;
   logic [DATA_WIDTH-1:0]  buf_q;
   logic                   buf_full_q;
   logic [DATA_WIDTH-1:0]  shift_q;
   logic [DATA_WIDTH-1:0]  shift_next;
   logic [CNT_W-1:0]       cnt_q;
   logic [SYNC_STAGES-1:0] mosi_q;
   logic                   mosi_sync;
   logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
   logic                   tx_accept, do_load;

   // cs idles high, so its chain resets high to avoid a phantom falling edge
   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
      .clk(clk), .rst(rst), .pin(sclk), .rise(sclk_rise), .fall(sclk_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
      .clk(clk), .rst(rst), .pin(cs), .rise(cs_rise), .fall(cs_fall)
   );

   // mosi only needs a plain synchronizer; it is sampled on the sclk fall pulse
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) mosi_q <= '0;
      else      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
   end

   assign mosi_sync  = mosi_q[SYNC_STAGES-1];
   assign shift_next = {shift_q[DATA_WIDTH-2:0], mosi_sync};
   assign tx_accept  = tx_valid && !buf_full_q;
   assign tx_ready   = !buf_full_q;
   assign busy       = (state_q == ST_SHIFT);

   // A word boundary: frame start, or the last falling edge of a word unless cs rises too
   assign do_load = ((state_q == ST_IDLE) && cs_fall) ||
                    ((state_q == ST_SHIFT) && !cs_rise && sclk_fall && (cnt_q == '0));

   // Buffer handshake, word loading, shifting and frame sequencing
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         buf_q       <= '0;
         buf_full_q  <= 1'b0;
         shift_q     <= '0;
         cnt_q       <= '0;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         tx_underrun <= 1'b0;
         frame_error <= 1'b0;
         miso        <= 1'b0;
         miso_oe     <= 1'b0;
      end else begin
         rx_valid    <= 1'b0;
         tx_underrun <= 1'b0;
         frame_error <= 1'b0;

         // A write never coincides with a consuming load: tx_ready is low while full
         if (tx_accept) begin
            buf_q      <= tx_data;
            buf_full_q <= 1'b1;
         end

         if (do_load) begin
            cnt_q <= LAST_BIT;
            if (buf_full_q) begin
               shift_q    <= buf_q;
               buf_full_q <= 1'b0;
            end else begin
               shift_q     <= '0;
               tx_underrun <= 1'b1;
            end
         end

         case (state_q)
            ST_IDLE: begin
               if (cs_fall) begin
                  state_q <= ST_SHIFT;
                  miso_oe <= 1'b1;
                  miso    <= 1'b0;
               end
            end
            default: begin
               if (cs_rise) begin
                  state_q     <= ST_IDLE;
                  miso_oe     <= 1'b0;
                  miso        <= 1'b0;
                  frame_error <= (cnt_q != LAST_BIT);
               end else begin
                  if (sclk_rise) miso <= shift_q[DATA_WIDTH-1];
                  if (sclk_fall) begin
                     if (cnt_q == '0) begin
                        rx_data  <= shift_next;
                        rx_valid <= 1'b1;
                     end else begin
                        shift_q <= shift_next;
                        cnt_q   <= cnt_q - 1'b1;
                     end
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_slave_port.sv
// tb/tb_spi_slave_port.sv - self-checking bench for spi_slave_port
module tb_spi_slave_port;

   localparam int HP   = 8;
   localparam int SYNC = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] tx_data = '0;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       busy;
   logic       tx_underrun;
   logic       frame_error;
   logic       sclk = 1'b0;
   logic       cs = 1'b1;
   logic       mosi = 1'b0;
   logic       miso;
   logic       miso_oe;

   int vectors = 0;
   int miscompares = 0;
   int fe_cnt = 0;
   int ur_cnt = 0;
   logic [7:0] rx_q[$];

   typedef struct {
      logic [7:0] tx;
      logic [7:0] mo;
      logic [7:0] exp_miso;
      logic [7:0] exp_rx;
   } vec_t;
   vec_t vecs[4];

   spi_slave_port #(.DATA_WIDTH(8), .SYNC_STAGES(SYNC)) dut (
      .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .tx_underrun(tx_underrun),
      .frame_error(frame_error), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso), .miso_oe(miso_oe)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic note_fail(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: bound expired", name);
   endtask

   // Scoreboard: every rx_valid pulse pops one expected word
   always @(negedge clk) begin
      if (rst) begin
         if (frame_error) fe_cnt++;
         if (tx_underrun) ur_cnt++;
         if (rx_valid) begin
            if (rx_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL rx_unexpected: got %0h, required no rx_valid", rx_data);
            end else begin
               check("rx_data", {24'd0, rx_data}, {24'd0, rx_q.pop_front()});
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic write_tx(input logic [7:0] d);
      int n = 0;
      while (!tx_ready && n < 400) begin
         tick(1);
         n++;
      end
      if (!tx_ready) note_fail("tx_ready_timeout");
      else begin
         tx_data  = d;
         tx_valid = 1'b1;
         tick(1);
         tx_valid = 1'b0;
      end
   endtask

   task automatic cs_down();
      cs = 1'b0;
      tick(HP);
   endtask

   task automatic cs_up();
      tick(HP);
      cs = 1'b1;
      tick(HP);
   endtask

   // Master side of mode 1: drive on rising sclk, sample miso at falling sclk
   task automatic xfer_bits(input logic [7:0] mo, input int nbits,
                            output logic [7:0] mi, output int lat);
      mi  = '0;
      lat = 0;
      for (int b = 7; b >= 8 - nbits; b--) begin
         sclk = 1'b1;
         mosi = mo[b];
         tick(HP);
         mi[b] = miso;
         sclk  = 1'b0;
         for (int k = 1; k <= HP; k++) begin
            tick(1);
            if (rx_valid && lat == 0) lat = k;
         end
      end
   endtask

   task automatic run_frame(input logic [7:0] tx, input logic [7:0] mo, input bit do_tx,
                            output logic [7:0] mi, output int lat);
      if (do_tx) write_tx(tx);
      rx_q.push_back(mo);
      cs_down();
      xfer_bits(mo, 8, mi, lat);
      cs_up();
   endtask

   initial begin
      logic [7:0] mi, mi2;
      int lat, fe0, ur0, n;

      vecs[0] = '{tx: 8'hA5, mo: 8'h3C, exp_miso: 8'hA5, exp_rx: 8'h3C};
      vecs[1] = '{tx: 8'h00, mo: 8'hFF, exp_miso: 8'h00, exp_rx: 8'hFF};
      vecs[2] = '{tx: 8'hFF, mo: 8'h00, exp_miso: 8'hFF, exp_rx: 8'h00};
      vecs[3] = '{tx: 8'h81, mo: 8'h7E, exp_miso: 8'h81, exp_rx: 8'h7E};

      // Reset state
      #3;
      check("rst_tx_ready", tx_ready, 1);
      check("rst_rx_data", rx_data, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_underrun", tx_underrun, 0);
      check("rst_frame_error", frame_error, 0);
      check("rst_miso", miso, 0);
      check("rst_miso_oe", miso_oe, 0);
      tick(3);
      rst = 1'b1;
      tick(3);

      // Single-word frames from the table
      foreach (vecs[i]) begin
         fe0 = fe_cnt;
         write_tx(vecs[i].tx);
         rx_q.push_back(vecs[i].exp_rx);
         cs_down();
         check("frame_busy", busy, 1);
         check("frame_miso_oe", miso_oe, 1);
         xfer_bits(vecs[i].mo, 8, mi, lat);
         cs_up();
         check("single_miso", mi, vecs[i].exp_miso);
         check("rx_latency", lat, SYNC + 2);
         check("single_no_frame_error", fe_cnt, fe0);
         check("idle_busy", busy, 0);
         check("idle_miso_oe", miso_oe, 0);
      end

      // Back-to-back words, second tx word written once tx_ready reasserts
      fe0 = fe_cnt;
      write_tx(8'h01);
      rx_q.push_back(8'hF0);
      rx_q.push_back(8'h0F);
      fork
         begin
            cs_down();
            xfer_bits(8'hF0, 8, mi, lat);
            xfer_bits(8'h0F, 8, mi2, lat);
            cs_up();
         end
         write_tx(8'h80);
      join
      check("b2b_miso0", mi, 8'h01);
      check("b2b_miso1", mi2, 8'h80);
      check("b2b_no_frame_error", fe_cnt, fe0);

      // Handshake: 0x22 waits until the load consumes 0x11
      tx_data  = 8'h11;
      tx_valid = 1'b1;
      check("hs_ready_first", tx_ready, 1);
      tick(1);
      tx_data = 8'h22;
      tick(3);
      check("hs_held_off", tx_ready, 0);
      rx_q.push_back(8'hC3);
      rx_q.push_back(8'h3C);
      fork
         begin
            cs_down();
            xfer_bits(8'hC3, 8, mi, lat);
            xfer_bits(8'h3C, 8, mi2, lat);
            cs_up();
         end
         begin
            n = 0;
            while (!tx_ready && n < 100) begin
               tick(1);
               n++;
            end
            if (!tx_ready) note_fail("hs_reopen_timeout");
            check("hs_reopen_after_load", busy, 1);
            tick(1);
            check("hs_second_taken", tx_ready, 0);
            tx_valid = 1'b0;
         end
      join
      tx_valid = 1'b0;
      check("hs_miso0", mi, 8'h11);
      check("hs_miso1", mi2, 8'h22);

      // Underrun: empty buffer at frame start
      ur0 = ur_cnt;
      rx_q.push_back(8'h96);
      cs_down();
      check("underrun_pulse", ur_cnt - ur0, 1);
      xfer_bits(8'h96, 8, mi, lat);
      cs_up();
      check("underrun_miso", mi, 8'h00);

      // Abort after three sclk periods
      fe0 = fe_cnt;
      write_tx(8'h77);
      cs_down();
      xfer_bits(8'hAA, 3, mi, lat);
      cs = 1'b1;
      tick(HP);
      check("abort_frame_error", fe_cnt - fe0, 1);
      check("abort_busy", busy, 0);
      check("abort_miso_oe", miso_oe, 0);
      run_frame(8'h3C, 8'hC3, 1'b1, mi, lat);
      check("after_abort_miso", mi, 8'h3C);

      // Asynchronous reset during bit 4
      write_tx(8'h99);
      cs_down();
      xfer_bits(8'hFF, 4, mi, lat);
      sclk = 1'b1;
      tick(3);
      rst = 1'b0;
      #2;
      check("mid_rst_tx_ready", tx_ready, 1);
      check("mid_rst_rx_data", rx_data, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_miso_oe", miso_oe, 0);
      check("mid_rst_miso", miso, 0);
      tick(2);
      sclk = 1'b0;
      cs   = 1'b1;
      tick(4);
      rst = 1'b1;
      tick(2);
      check("post_rst_tx_ready", tx_ready, 1);
      sclk = 1'b1;
      tick(HP);
      sclk = 1'b0;
      tick(HP);
      check("cs_high_sclk_ignored", busy, 0);
      run_frame(8'hE7, 8'h5A, 1'b1, mi, lat);
      check("post_rst_miso", mi, 8'hE7);

      tick(10);
      check("rx_pending", rx_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
